// File: rtl/shake_pkg.sv
// shake_pkg: shared constants and the rate block serializer state encoding.
package shake_pkg;

    localparam int unsigned RATE_BITS        = 1088;
    localparam int unsigned RATE_BYTES       = RATE_BITS / 8;
    localparam int unsigned CHUNKS_PER_BLOCK = RATE_BYTES * 4;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitBlk = 2'd1,
        StShift   = 2'd2,
        StDone    = 2'd3
    } ser_state_e;

endpackage

// File: rtl/rate_block_serializer.sv
// rate_block_serializer: requests rate blocks and streams their bytes out as 2-bit chunks,
// byte 0 first and LSB-first within each byte, until the requested byte count is emitted.
// Optional: define RATE_SER_STATS_EN to add the blocks_used (blocks consumed) output.
module rate_block_serializer #(
    parameter int unsigned RATE_BITS = shake_pkg::RATE_BITS,
    parameter int unsigned LEN_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_W-1:0]     out_bytes,
    input  logic [RATE_BITS-1:0] block_in,
    input  logic                 block_valid,
    output logic                 block_ready,
    output logic [1:0]           serial_out,
    output logic                 serial_valid,
    input  logic                 serial_ready,
    output logic                 serial_last,
    output logic                 done
`ifdef RATE_SER_STATS_EN
    ,
    output logic [7:0]           blocks_used
`endif
);
    import shake_pkg::*;

    localparam int unsigned NumBytes = RATE_BITS / 8;
    localparam int unsigned IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;

    ser_state_e           state_q, state_d;
    logic [LEN_W-1:0]     remaining_q, remaining_d;
    logic [IdxW-1:0]      byte_idx_q, byte_idx_d;
    logic [1:0]           chunk_cnt_q, chunk_cnt_d;
    logic [RATE_BITS-1:0] shift_q, shift_d;

    logic start_accept;
    logic blk_xfer;
    logic last_byte;

    assign start_accept = start && ((state_q == StIdle) || (state_q == StDone));
    assign blk_xfer     = (state_q == StWaitBlk) && block_valid;
    assign last_byte    = (byte_idx_q == IdxW'(NumBytes - 1));

    // State, counters and shift register, synchronously cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            byte_idx_q  <= '0;
            chunk_cnt_q <= '0;
            shift_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            byte_idx_q  <= byte_idx_d;
            chunk_cnt_q <= chunk_cnt_d;
            shift_q     <= shift_d;
        end
    end

    // Next-state: latch request, load blocks, step chunks and bytes.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        byte_idx_d  = byte_idx_q;
        chunk_cnt_d = chunk_cnt_q;
        shift_d     = shift_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_accept) begin
                    remaining_d = out_bytes;
                    state_d     = (out_bytes == '0) ? StDone : StWaitBlk;
                end
            end
            StWaitBlk: begin
                if (blk_xfer) begin
                    shift_d     = block_in;
                    byte_idx_d  = '0;
                    chunk_cnt_d = '0;
                    state_d     = StShift;
                end
            end
            StShift: begin
                if (serial_ready) begin
                    shift_d     = shift_q >> 2;
                    chunk_cnt_d = chunk_cnt_q + 2'd1;
                    if (chunk_cnt_q == 2'd3) begin
                        // remaining is never 0 here: SHIFT is only entered with bytes owed
                        remaining_d = remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_d    = StDone;
                            byte_idx_d = '0;
                        end else if (last_byte) begin
                            state_d    = StWaitBlk;
                            byte_idx_d = '0;
                        end else begin
                            byte_idx_d = byte_idx_q + IdxW'(1);
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state; serial_out forced low when not valid.
    always_comb begin
        block_ready  = (state_q == StWaitBlk);
        serial_valid = (state_q == StShift);
        serial_out   = serial_valid ? shift_q[1:0] : 2'b00;
        serial_last  = serial_valid && (remaining_q == LEN_W'(1)) && (chunk_cnt_q == 2'd3);
        done         = (state_q == StDone);
    end

`ifdef RATE_SER_STATS_EN
    logic [7:0] blocks_used_q;

    // Blocks consumed by the current request, saturating at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            blocks_used_q <= '0;
        end else if (start_accept) begin
            blocks_used_q <= '0;
        end else if (blk_xfer && (blocks_used_q != 8'hFF)) begin
            blocks_used_q <= blocks_used_q + 8'd1;
        end
    end

    assign blocks_used = blocks_used_q;
`endif

endmodule

// File: tb/tb_rate_block_serializer.sv
// tb_rate_block_serializer: randomized self-checking bench; expected chunk stream is built
// from the bytes of every block handed to the DUT.
module tb_rate_block_serializer;

    localparam int RB  = 1088;
    localparam int NB  = RB / 8;
    localparam int CPB = NB * 4;
    localparam int LW  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] out_bytes;
    logic [RB-1:0] block_in;
    logic          block_valid;
    logic          block_ready;
    logic [1:0]    serial_out;
    logic          serial_valid;
    logic          serial_ready;
    logic          serial_last;
    logic          done;
`ifdef RATE_SER_STATS_EN
    logic [7:0]    blocks_used;
`endif

    int checks = 0;
    int errors = 0;

    rate_block_serializer #(
        .RATE_BITS (RB),
        .LEN_W     (LW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .out_bytes    (out_bytes),
        .block_in     (block_in),
        .block_valid  (block_valid),
        .block_ready  (block_ready),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .serial_ready (serial_ready),
        .serial_last  (serial_last),
        .done         (done)
`ifdef RATE_SER_STATS_EN
        ,
        .blocks_used  (blocks_used)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [RB-1:0] rand_block();
        logic [RB-1:0] b;
        for (int i = 0; i < RB / 32; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    // One request. rmode: 0 ready always, 1 alternating 1,0,..., 2 random.
    // vmode: 0 block_valid always, 1 random. Byte 0 of block ovr_blk is forced to ovr_byte.
    // spur: pulse stray starts while busy. abort_after>0: return after that many chunks.
    task automatic run_request(input int len, input int rmode, input int vmode,
                               input int ovr_blk, input logic [7:0] ovr_byte,
                               input bit spur, input int abort_after);
        logic [1:0]    exp_q[$];
        logic [RB-1:0] blk;
        logic [7:0]    byte_v;
        logic [1:0]    prev_out;
        logic          prev_last;
        int idx, blocks, total, bound, exp_blocks;
        bit chk_br, chk_sv, chk_done, prev_hold, alt, finished, spur_seen;
        idx = 0; blocks = 0; total = len * 4; bound = 20 * total + 100;
        chk_br = 0; chk_sv = 0; chk_done = 0; prev_hold = 0; alt = 1;
        finished = 0; spur_seen = 0; prev_out = 2'b00; prev_last = 1'b0;
        @(negedge clk);
        start = 1'b1; out_bytes = LW'(len); block_valid = 1'b0; serial_ready = 1'b0;
        if (len == 0) chk_done = 1; else chk_br = 1;
        for (int cyc = 0; cyc < bound && !finished; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (chk_br) begin
                checks++;
                if (block_ready !== 1'b1) begin
                    errors++; $display("FAIL block_ready_next got %b exp 1 (len %0d idx %0d)", block_ready, len, idx);
                end
            end
            if (chk_sv) begin
                checks++;
                if (serial_valid !== 1'b1) begin
                    errors++; $display("FAIL serial_valid_next got %b exp 1 (len %0d idx %0d)", serial_valid, len, idx);
                end
            end
            if (chk_done) begin
                checks++;
                if (done !== 1'b1) begin
                    errors++; $display("FAIL done_next got %b exp 1 (len %0d)", done, len);
                end
            end
            chk_br = 0; chk_sv = 0; chk_done = 0;
            if (serial_valid !== 1'b1) begin
                checks++;
                if (serial_out !== 2'b00) begin
                    errors++; $display("FAIL idle_serial_out got %b exp 00", serial_out);
                end
            end
            if (prev_hold) begin
                checks++;
                if ({serial_valid, serial_out, serial_last} !== {1'b1, prev_out, prev_last}) begin
                    errors++;
                    $display("FAIL hold_stable got v%b o%b l%b exp v1 o%b l%b", serial_valid, serial_out,
                             serial_last, prev_out, prev_last);
                end
            end
            if (done === 1'b1) begin
                finished = 1;
            end else begin
                case (rmode)
                    0:       serial_ready = 1'b1;
                    1:       serial_ready = alt;
                    default: serial_ready = 1'($urandom_range(0, 1));
                endcase
                alt = !alt;
                block_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                blk = rand_block();
                if (blocks == ovr_blk) blk[7:0] = ovr_byte;
                block_in = blk;
                if (spur && (block_ready || serial_valid) && $urandom_range(0, 7) == 0) begin
                    start = 1'b1; out_bytes = LW'($urandom()); spur_seen = 1;
                end
                if (block_ready && block_valid) begin
                    for (int j = 0; j < NB; j++) begin
                        byte_v = blk[8*j +: 8];
                        for (int k = 0; k < 4; k++) exp_q.push_back(2'((byte_v >> (2 * k)) & 8'd3));
                    end
                    blocks++;
                    chk_sv = 1;
                end
                if (serial_valid && serial_ready) begin
                    checks++;
                    if (idx >= total || idx >= exp_q.size()) begin
                        errors++; $display("FAIL extra_chunk idx %0d total %0d", idx, total);
                    end else if (serial_out !== exp_q[idx] || serial_last !== (idx == total - 1)) begin
                        errors++;
                        $display("FAIL chunk idx %0d got %b last %b exp %b last %b", idx, serial_out,
                                 serial_last, exp_q[idx], (idx == total - 1));
                    end
                    idx++;
                    if (idx == total) chk_done = 1;
                    else if (idx % CPB == 0) chk_br = 1;
                    else chk_sv = 1;
                end
                prev_hold = serial_valid && !serial_ready;
                prev_out  = serial_out;
                prev_last = serial_last;
                if (abort_after > 0 && idx == abort_after) return;
            end
        end
        exp_blocks = (len + NB - 1) / NB;
        checks++;
        if (!finished) begin
            errors++; $display("FAIL timeout len %0d idx %0d exp done", len, idx);
        end
        checks++;
        if (idx != total) begin
            errors++; $display("FAIL chunk_count got %0d exp %0d", idx, total);
        end
        checks++;
        if (blocks != exp_blocks) begin
            errors++; $display("FAIL block_count got %0d exp %0d", blocks, exp_blocks);
        end
`ifdef RATE_SER_STATS_EN
        if (!spur_seen) begin
            checks++;
            if (int'(blocks_used) != ((blocks > 255) ? 255 : blocks)) begin
                errors++; $display("FAIL blocks_used got %0d exp %0d", blocks_used, blocks);
            end
        end
`endif
    endtask

    task automatic check_all_low(input string name);
        checks++;
        if ({block_ready, serial_valid, serial_last, done, serial_out} !== 6'b0) begin
            errors++;
            $display("FAIL %s got br%b sv%b sl%b d%b so%b exp all 0", name, block_ready, serial_valid,
                     serial_last, done, serial_out);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_bytes = '0; block_in = '0;
        block_valid = 1'b1; serial_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_all_low("reset_outputs");
`ifdef RATE_SER_STATS_EN
        checks++;
        if (blocks_used !== 8'd0) begin
            errors++; $display("FAIL reset_blocks_used got %0d exp 0", blocks_used);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
        check_all_low("idle_after_reset");
    endtask

    task automatic test_single_byte();
        run_request(1, 0, 0, 0, 8'hB4, 0, 0);
    endtask

    task automatic test_exact_block();
        run_request(NB, 0, 0, -1, 8'h00, 0, 0);
    endtask

    task automatic test_block_boundary();
        run_request(NB + 1, 0, 0, 1, 8'h5A, 0, 0);
    endtask

    task automatic test_backpressure();
        run_request(40, 1, 0, -1, 8'h00, 0, 0);
    endtask

    task automatic test_zero_len();
        run_request(0, 0, 0, -1, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (block_ready !== 1'b0 || done !== 1'b1) begin
                errors++; $display("FAIL zero_len_idle got br%b d%b exp br0 d1", block_ready, done);
            end
        end
    endtask

    task automatic test_reset_mid();
        run_request(200, 0, 0, -1, 8'h00, 0, 10);
        @(negedge clk);
        reset = 1'b1; serial_ready = 1'b0; block_valid = 1'b0;
        @(negedge clk);
        check_all_low("reset_mid_outputs");
        reset = 1'b0; serial_ready = 1'b1; block_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_all_low("idle_after_mid_reset");
        end
        run_request(1, 0, 0, 0, 8'hC3, 0, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            run_request(int'($urandom_range(1, 300)), 2, 1, -1, 8'h00, 1, 0);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_exact_block();
        test_block_boundary();
        test_backpressure();
        test_zero_len();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
